// File: rtl/serline_pkg.sv
// Shared serial-line definitions: frame shape, receive core states and bit timing limit.
package serline_pkg;
    localparam int          DATA_BITS   = 8;
    localparam logic        IDLE_LVL    = 1'b1;
    localparam logic [15:0] MIN_BIT_LEN = 16'd4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rcv_state_e;
endpackage

// File: rtl/rcvbuf_rcv.sv
// Receive core: two-flop line synchronizer and 8N1 frame FSM sampling mid-bit.
module rcv
    import serline_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] bit_len,
    input  logic        serial_in,
    output logic        done,
    output logic        ferr,
    output logic [7:0]  data
);
    logic        s1_q, s2_q, prev_q;
    logic [2:0]  arm_q;
    rcv_state_e  state_q, state_d;
    logic [15:0] cnt_q, cnt_d, len_q, len_d, blen;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  sr_q, sr_d;
    logic        rx, fall, expire;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q    <= IDLE_LVL;
            s2_q    <= IDLE_LVL;
            prev_q  <= IDLE_LVL;
            arm_q   <= 3'b000;
            state_q <= IDLE;
            cnt_q   <= 16'd0;
            len_q   <= MIN_BIT_LEN;
            idx_q   <= 3'd0;
            sr_q    <= 8'h00;
        end else begin
            s1_q    <= serial_in;
            s2_q    <= s1_q;
            prev_q  <= s2_q;
            arm_q   <= {arm_q[1:0], 1'b1};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            sr_q    <= sr_d;
        end
    end

    // Edges are trusted only once the preset synchronizer values have flushed,
    // so a line held low across reset never looks like a start bit.
    assign rx     = s2_q;
    assign fall   = arm_q[2] & prev_q & ~rx;
    assign expire = (cnt_q <= 16'd1);
    assign blen   = (bit_len < MIN_BIT_LEN) ? MIN_BIT_LEN : bit_len;
    assign data   = sr_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        idx_d   = idx_q;
        sr_d    = sr_q;
        done    = 1'b0;
        ferr    = 1'b0;
        case (state_q)
            IDLE: begin
                if (fall) begin
                    len_d   = blen;
                    cnt_d   = blen >> 1;
                    state_d = START;
                end
            end
            START: begin
                if (!expire) begin
                    cnt_d = cnt_q - 16'd1;
                end else if (rx) begin
                    state_d = IDLE;
                end else begin
                    cnt_d   = len_q;
                    idx_d   = 3'd0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (!expire) begin
                    cnt_d = cnt_q - 16'd1;
                end else begin
                    sr_d  = {rx, sr_q[7:1]};
                    cnt_d = len_q;
                    idx_d = idx_q + 3'd1;
                    if (idx_q == 3'(DATA_BITS - 1)) state_d = STOP;
                end
            end
            STOP: begin
                if (!expire) begin
                    cnt_d = cnt_q - 16'd1;
                end else begin
                    done    = rx;
                    ferr    = ~rx;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: rtl/rcvbuf.sv
// Receiver with one-byte holding buffer, ready/read handshake and sticky error flags.
module rcvbuf
    import serline_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] bit_len,
    input  logic        read,
    output logic        ready,
    output logic [7:0]  data_out,
    output logic        framing_err,
    output logic        overrun,
    input  logic        serial_in
);
    logic       done, ferr;
    logic [7:0] rx_byte;
    logic       ready_q, ready_d, fe_q, fe_d, ovr_q, ovr_d;
    logic [7:0] data_q, data_d;

    rcv u_rcv (
        .clk       (clk),
        .rst       (rst),
        .bit_len   (bit_len),
        .serial_in (serial_in),
        .done      (done),
        .ferr      (ferr),
        .data      (rx_byte)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            ready_q <= 1'b0;
            data_q  <= 8'h00;
            fe_q    <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            ready_q <= ready_d;
            data_q  <= data_d;
            fe_q    <= fe_d;
            ovr_q   <= ovr_d;
        end
    end

    // A new byte always wins the buffer; it only counts as overrun if the
    // old one was left unread in the same cycle.
    always_comb begin
        ready_d = ready_q;
        data_d  = data_q;
        fe_d    = fe_q;
        ovr_d   = ovr_q;
        if (done) begin
            data_d  = rx_byte;
            ready_d = 1'b1;
            if (ready_q && !read) ovr_d = 1'b1;
        end else if (read && ready_q) begin
            ready_d = 1'b0;
            fe_d    = 1'b0;
            ovr_d   = 1'b0;
        end
        if (ferr) fe_d = 1'b1;
    end

    assign ready       = ready_q;
    assign data_out    = data_q;
    assign framing_err = fe_q;
    assign overrun     = ovr_q;
endmodule

// File: tb/tb_rcvbuf.sv
// Directed and random frames against a transaction-level model of the receive buffer.
module tb_rcvbuf;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] bit_len = 16'd16;
    logic        read = 1'b0;
    logic        serial_in = 1'b1;
    logic        ready, framing_err, overrun;
    logic [7:0]  data_out;

    int errs = 0;
    int checks = 0;

    // model state: what the host should see
    logic       m_ready = 1'b0;
    logic [7:0] m_data = 8'h00;
    logic       m_fe = 1'b0;
    logic       m_ovr = 1'b0;

    rcvbuf dut (
        .clk         (clk),
        .rst         (rst),
        .bit_len     (bit_len),
        .read        (read),
        .ready       (ready),
        .data_out    (data_out),
        .framing_err (framing_err),
        .overrun     (overrun),
        .serial_in   (serial_in)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, "_ready"}, 32'(ready), 32'(m_ready));
        check({tag, "_data"}, 32'(data_out), 32'(m_data));
        check({tag, "_ferr"}, 32'(framing_err), 32'(m_fe));
        check({tag, "_ovr"}, 32'(overrun), 32'(m_ovr));
    endtask

    task automatic m_frame(input logic [7:0] b, input bit good);
        if (good) begin
            if (m_ready) m_ovr = 1'b1;
            m_data  = b;
            m_ready = 1'b1;
        end else begin
            m_fe = 1'b1;
        end
    endtask

    task automatic m_reset();
        m_ready = 1'b0; m_data = 8'h00; m_fe = 1'b0; m_ovr = 1'b0;
    endtask

    // called at a negedge; read is sampled by the following posedge
    task automatic pulse_read();
        read = 1'b1;
        @(negedge clk);
        read = 1'b0;
        if (m_ready) begin
            m_ready = 1'b0; m_fe = 1'b0; m_ovr = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input bit stop, input int bl);
        logic [9:0] bits;
        bits = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            serial_in = bits[i];
            repeat (bl) @(negedge clk);
        end
        serial_in = 1'b1;
    endtask

    task automatic wait_ready(input int limit, output int cyc);
        cyc = 0;
        while (!ready && cyc < limit) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    initial begin
        int cyc;
        logic [7:0] q[$];
        repeat (3) @(negedge clk);
        check_all("reset");
        rst = 1'b0;
        repeat (6) @(negedge clk);

        // single frame, latency, read
        fork
            send_frame(8'hA5, 1'b1, 16);
            begin
                wait_ready(200, cyc);
                check("t1_latency_in_range", 32'(cyc >= 150 && cyc <= 156), 32'd1);
            end
        join
        repeat (6) @(negedge clk);
        m_frame(8'hA5, 1'b1);
        check_all("t1_rx");
        pulse_read();
        check_all("t1_read");

        // overrun: two frames without a read
        send_frame(8'h3C, 1'b1, 16); repeat (6) @(negedge clk); m_frame(8'h3C, 1'b1);
        send_frame(8'hC3, 1'b1, 16); repeat (6) @(negedge clk); m_frame(8'hC3, 1'b1);
        check_all("t2_ovr");
        pulse_read();
        check_all("t2_read");

        // framing error, then a good frame, flag sticky until read
        send_frame(8'h55, 1'b0, 16); repeat (6) @(negedge clk); m_frame(8'h55, 1'b0);
        check_all("t3_ferr");
        send_frame(8'h01, 1'b1, 16); repeat (6) @(negedge clk); m_frame(8'h01, 1'b1);
        check_all("t3_good");
        pulse_read();
        check_all("t3_read");

        // short low glitch must be rejected
        serial_in = 1'b0;
        repeat (4) @(negedge clk);
        serial_in = 1'b1;
        repeat (30) @(negedge clk);
        check_all("t4_glitch");
        send_frame(8'h7E, 1'b1, 16); repeat (6) @(negedge clk); m_frame(8'h7E, 1'b1);
        check_all("t4_rx");

        // reset in the middle of data bits (all-zero byte so no stray edges follow)
        fork
            send_frame(8'h00, 1'b1, 16);
            begin
                repeat (60) @(negedge clk);
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                m_reset();
                check_all("t5_rst");
            end
        join
        repeat (6) @(negedge clk);
        check_all("t5_quiet");
        send_frame(8'h81, 1'b1, 16); repeat (6) @(negedge clk); m_frame(8'h81, 1'b1);
        check_all("t5_rx");
        pulse_read();

        // back-to-back frames at the minimum bit length
        bit_len = 16'd4;
        q = '{8'h00, 8'hFF, 8'h5A};
        fork
            begin
                send_frame(8'h00, 1'b1, 4);
                send_frame(8'hFF, 1'b1, 4);
                send_frame(8'h5A, 1'b1, 4);
            end
            begin
                for (int i = 0; i < 3; i++) begin
                    wait_ready(100, cyc);
                    check("t6_ready_seen", 32'(ready), 32'd1);
                    m_frame(q[i], 1'b1);
                    check_all("t6_b2b");
                    pulse_read();
                end
            end
        join
        repeat (6) @(negedge clk);
        check_all("t6_end");

        // random frames, lengths, stop bits and reads
        for (int n = 0; n < 12; n++) begin
            int bl;
            logic [7:0] b;
            bit good;
            bl   = int'($urandom_range(4, 24));
            b    = 8'($urandom);
            good = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 1) == 1) pulse_read();
            bit_len = 16'(bl);
            repeat ($urandom_range(2, 10)) @(negedge clk);
            send_frame(b, good, bl);
            repeat (6) @(negedge clk);
            m_frame(b, good);
            check_all("rand");
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
